// File: rtl/mandel_pkg.sv
// mandel_pkg -- shared widths, frame defaults and scheduler state encoding for the Mandelbrot line path.
// Rev 1.0
`default_nettype none

package mandel_pkg;

   localparam int DEPTH_W    = 10;
   localparam int X_W        = 10;
   localparam int Y_W        = 9;
   localparam int DEF_X_SIZE = 640;
   localparam int DEF_Y_SIZE = 480;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // Position of the set bit in a one-hot vector; zero when no bit is set.
   function automatic int onehot_to_idx(input logic [31:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter -- one-hot round-robin grant; priority restarts just after the last granted requester.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] cand;
   logic [PW-1:0] gidx;
   logic          found;

   always_comb begin
      grant = '0;
      gidx  = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand = PW'((int'(ptr) + k) % N);
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            found       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en && found) begin
         ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/line_job_scheduler.sv
// line_job_scheduler -- issues one line of pixel jobs to a pool of engines and writes results back out of order.
// Rev 1.0
`default_nettype none

module line_job_scheduler
   import mandel_pkg::*;
#(
   parameter int NUM_ENGINES = 4,
   parameter int X_SIZE      = DEF_X_SIZE,
   parameter int Y_SIZE      = DEF_Y_SIZE
) (
   input  logic                           out_stream_aclk,
   input  logic                           periph_resetn,
   input  logic                           start,
   output logic                           busy,
   output logic                           line_done,
   output logic [NUM_ENGINES-1:0]         job_valid,
   output logic [X_W-1:0]                 job_x,
   output logic [Y_W-1:0]                 job_y,
   input  logic [NUM_ENGINES-1:0]         eng_ready,
   input  logic [NUM_ENGINES-1:0]         res_valid,
   input  logic [NUM_ENGINES*DEPTH_W-1:0] res_depth,
   output logic [NUM_ENGINES-1:0]         res_ack,
   output logic                           wr_en,
   output logic [X_W-1:0]                 wr_addr,
   output logic [DEPTH_W-1:0]             wr_data
);

   localparam int IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);

   state_t                   state;
   state_t                   state_nxt;
   logic [X_W-1:0]           next_x;
   logic [X_W-1:0]           written;
   logic [NUM_ENGINES-1:0]   inflight;
   logic [X_W-1:0]           eng_x     [NUM_ENGINES];
   logic [DEPTH_W-1:0]       depth_arr [NUM_ENGINES];
   logic [NUM_ENGINES-1:0]   issue_req;
   logic [NUM_ENGINES-1:0]   issue_gnt;
   logic [NUM_ENGINES-1:0]   coll_req;
   logic [NUM_ENGINES-1:0]   coll_gnt;
   logic                     issue_phase;
   logic                     coll_phase;
   logic [IW-1:0]            iss_idx;
   logic [IW-1:0]            ack_idx;

   for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_unpack_depth
      assign depth_arr[g] = res_depth[g*DEPTH_W +: DEPTH_W];
   end

   // An engine is eligible for a new job only once its previous result has been collected.
   assign issue_phase = (state == ST_DISPATCH);
   assign coll_phase  = (state == ST_DISPATCH) || (state == ST_DRAIN);
   assign issue_req   = issue_phase ? (eng_ready & ~inflight) : '0;
   assign coll_req    = coll_phase  ? (res_valid &  inflight) : '0;

   rr_arbiter #(.N(NUM_ENGINES)) u_issue_rr (
      .clk   (out_stream_aclk),
      .rst_n (periph_resetn),
      .req   (issue_req),
      .en    (issue_phase),
      .grant (issue_gnt)
   );

   rr_arbiter #(.N(NUM_ENGINES)) u_coll_rr (
      .clk   (out_stream_aclk),
      .rst_n (periph_resetn),
      .req   (coll_req),
      .en    (coll_phase),
      .grant (coll_gnt)
   );

   assign iss_idx   = IW'(onehot_to_idx(32'(issue_gnt)));
   assign ack_idx   = IW'(onehot_to_idx(32'(coll_gnt)));
   assign job_valid = issue_gnt;
   assign res_ack   = coll_gnt;
   assign job_x     = next_x;

   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      line_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_DISPATCH;
         end
         ST_DISPATCH: begin
            busy = 1'b1;
            if ((|issue_gnt) && (next_x == X_LAST)) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (wr_en && (written == X_LAST)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            line_done = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         next_x   <= '0;
         written  <= '0;
         inflight <= '0;
         job_y    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wr_en <= |coll_gnt;
         if (|coll_gnt) begin
            wr_addr <= eng_x[ack_idx];
            wr_data <= depth_arr[ack_idx];
         end
         if ((state == ST_IDLE) && start) begin
            next_x   <= '0;
            written  <= '0;
            inflight <= '0;
         end else begin
            inflight <= (inflight & ~coll_gnt) | issue_gnt;
            if (|issue_gnt) next_x <= next_x + 1'b1;
            if (wr_en) written <= written + 1'b1;
         end
         if (state == ST_DONE) begin
            job_y <= (job_y == Y_LAST) ? '0 : job_y + 1'b1;
         end
      end
   end

   // Column tag per engine; meaningless while the engine is idle, so no reset needed.
   always_ff @(posedge out_stream_aclk) begin
      if (|issue_gnt) eng_x[iss_idx] <= next_x;
   end

endmodule

`default_nettype wire

// File: tb/tb_line_job_scheduler.sv
// tb_line_job_scheduler -- directed and randomised lines against a behavioural engine-pool model.
// Rev 1.0
`default_nettype none

module tb_line_job_scheduler;

   localparam int NE = 4;
   localparam int XS = 8;
   localparam int YS = 3;

   logic          clk = 1'b0;
   logic          periph_resetn;
   logic          start;
   logic          busy;
   logic          line_done;
   logic [NE-1:0] job_valid;
   logic [9:0]    job_x;
   logic [8:0]    job_y;
   logic [NE-1:0] eng_ready;
   logic [NE-1:0] res_valid;
   logic [NE*10-1:0] res_depth;
   logic [NE-1:0] res_ack;
   logic          wr_en;
   logic [9:0]    wr_addr;
   logic [9:0]    wr_data;

   always #5 clk = ~clk;

   line_job_scheduler #(.NUM_ENGINES(NE), .X_SIZE(XS), .Y_SIZE(YS)) dut (
      .out_stream_aclk (clk),
      .periph_resetn   (periph_resetn),
      .start           (start),
      .busy            (busy),
      .line_done       (line_done),
      .job_valid       (job_valid),
      .job_x           (job_x),
      .job_y           (job_y),
      .eng_ready       (eng_ready),
      .res_valid       (res_valid),
      .res_depth       (res_depth),
      .res_ack         (res_ack),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: line phase (0 idle, 1 active, 2 done cycle), pixel counters, engine pool.
   int         m_state, issued, written, iss_ptr, ack_ptr, m_y, cyc, done_cnt;
   logic [3:0] hold, mask;
   int         cnt [NE];
   int         ex  [NE];
   int         lat [NE];
   bit         rand_mode, stray_en;
   logic [9:0] depth_tab [XS];
   bit         exp_wr_v;
   int         exp_wr_addr;
   logic [9:0] exp_wr_data;
   int         wr_count [XS];
   int         wr_order [$];
   int         iss_eng  [$];
   logic [3:0] ack_log  [$];
   int         ack_cyc  [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] rr_pick(input logic [3:0] req, input int ptr);
      logic [3:0] g;
      int id;
      g = 4'b0;
      for (int k = 0; k < NE; k++) begin
         id = (ptr + k) % NE;
         if (g == 4'b0 && req[id]) g[id] = 1'b1;
      end
      return g;
   endfunction

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < NE; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic drive_engines();
      for (int i = 0; i < NE; i++) begin
         eng_ready[i] = !hold[i] && mask[i];
         if (hold[i]) begin
            res_valid[i]        = (cnt[i] == 0);
            res_depth[i*10 +: 10] = depth_tab[ex[i]];
         end else begin
            res_valid[i]        = stray_en && ($urandom_range(0, 3) == 0);
            res_depth[i*10 +: 10] = 10'($urandom);
         end
      end
   endtask

   task automatic model_cycle();
      logic [3:0] ejv, eack;
      int ii, jj;
      chk("job_y", 32'(job_y), 32'(m_y));
      case (m_state)
         0: begin
            chk("idle_busy", 32'(busy), 0);
            chk("idle_line_done", 32'(line_done), 0);
            chk("idle_job_valid", 32'(job_valid), 0);
            chk("idle_res_ack", 32'(res_ack), 0);
            chk("idle_wr_en", 32'(wr_en), 0);
            if (start) begin
               m_state = 1; issued = 0; written = 0;
               for (int x = 0; x < XS; x++) begin
                  wr_count[x]  = 0;
                  depth_tab[x] = 10'($urandom);
               end
               wr_order.delete(); iss_eng.delete(); ack_log.delete(); ack_cyc.delete();
            end
         end
         1: begin
            chk("act_busy", 32'(busy), 1);
            chk("act_line_done", 32'(line_done), 0);
            ejv = (issued < XS) ? rr_pick(eng_ready, iss_ptr) : 4'b0;
            chk("job_valid", 32'(job_valid), 32'(ejv));
            if (ejv != 4'b0) chk("job_x", 32'(job_x), 32'(issued));
            eack = rr_pick(res_valid & hold, ack_ptr);
            chk("res_ack", 32'(res_ack), 32'(eack));
            chk("wr_en", 32'(wr_en), 32'(exp_wr_v));
            if (exp_wr_v) begin
               chk("wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
               chk("wr_data", 32'(wr_data), 32'(exp_wr_data));
               written++;
               wr_count[exp_wr_addr]++;
               wr_order.push_back(exp_wr_addr);
            end
            exp_wr_v = 1'b0;
            if (eack != 4'b0) begin
               jj = idx_of(eack);
               exp_wr_v = 1'b1; exp_wr_addr = ex[jj]; exp_wr_data = depth_tab[ex[jj]];
               hold[jj] = 1'b0; ack_ptr = (jj + 1) % NE;
               ack_log.push_back(eack); ack_cyc.push_back(cyc);
            end
            for (int i = 0; i < NE; i++) if (hold[i] && cnt[i] > 0) cnt[i]--;
            if (ejv != 4'b0) begin
               ii = idx_of(ejv);
               hold[ii] = 1'b1; ex[ii] = issued; cnt[ii] = lat[ii];
               issued++; iss_ptr = (ii + 1) % NE; iss_eng.push_back(ii);
            end
            if (written == XS) m_state = 2;
         end
         default: begin
            chk("done_line_done", 32'(line_done), 1);
            chk("done_busy", 32'(busy), 0);
            chk("done_job_valid", 32'(job_valid), 0);
            chk("done_res_ack", 32'(res_ack), 0);
            chk("done_wr_en", 32'(wr_en), 0);
            done_cnt++;
            m_y = (m_y + 1) % YS;
            m_state = 0;
         end
      endcase
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (rand_mode) mask = 4'($urandom);
      drive_engines();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_line_done"}, 32'(line_done), 0);
      chk({tag, "_job_valid"}, 32'(job_valid), 0);
      chk({tag, "_res_ack"}, 32'(res_ack), 0);
      chk({tag, "_wr_en"}, 32'(wr_en), 0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
      chk({tag, "_wr_data"}, 32'(wr_data), 0);
      chk({tag, "_job_y"}, 32'(job_y), 0);
   endtask

   task automatic model_reset();
      m_state = 0; m_y = 0; iss_ptr = 0; ack_ptr = 0;
      hold = 4'b0; exp_wr_v = 1'b0; mask = 4'hF;
      for (int i = 0; i < NE; i++) cnt[i] = 0;
      drive_engines();
   endtask

   task automatic do_reset();
      periph_resetn = 1'b0;
      start = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      periph_resetn = 1'b1;
   endtask

   task automatic run_line(input bit busy_starts, input int stall);
      int budget;
      if (stall > 0) begin
         mask = 4'b0;
         drive_engines();
      end
      start = 1'b1;
      step();
      start = 1'b0;
      for (int s = 0; s < stall; s++) begin
         chk("stall_busy", 32'(busy), 1);
         step();
      end
      if (stall > 0) begin
         mask = 4'hF;
         drive_engines();
         #1;
         chk("stall_resume", 32'(job_valid != 4'b0), 1);
      end
      budget = 0;
      while (m_state != 0 && budget < 3000) begin
         if (busy_starts && $urandom_range(0, 5) == 0) start = 1'b1;
         step();
         start = 1'b0;
         budget++;
      end
      chk("line_timeout", 32'(budget < 3000), 1);
      for (int x = 0; x < XS; x++) chk("wr_once", 32'(wr_count[x]), 1);
      chk("wr_total", 32'(wr_order.size()), XS);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, ooo, lastw, issue_wait;
      cyc = 0; done_cnt = 0; rand_mode = 1'b0; stray_en = 1'b0;
      for (int i = 0; i < NE; i++) begin lat[i] = 3; ex[i] = 0; end
      for (int x = 0; x < XS; x++) begin depth_tab[x] = 10'd0; wr_count[x] = 0; end
      eng_ready = '0; res_valid = '0; res_depth = '0;
      periph_resetn = 1'b0;
      start = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      periph_resetn = 1'b1;

      // Line 0: all ready, fixed latency -> strict rotation 0,1,2,3,0,1,2,3
      d0 = done_cnt;
      run_line(1'b0, 0);
      for (int k = 0; k < XS; k++) chk("t1_engine_order", 32'(iss_eng[k]), 32'(k % NE));
      chk("t1_line_done_once", 32'(done_cnt - d0), 1);
      chk("t1_job_y_after", 32'(job_y), 1);

      // Line 1: engine 2 slow -> column 2 written last, order scrambled
      lat[0] = 0; lat[1] = 0; lat[2] = 20; lat[3] = 0;
      run_line(1'b0, 0);
      lastw = wr_order[wr_order.size() - 1];
      chk("t2_last_addr", 32'(lastw), 2);
      ooo = 0;
      for (int k = 0; k < wr_order.size(); k++) if (wr_order[k] != k) ooo = 1;
      chk("t2_out_of_order", 32'(ooo), 1);
      chk("t2_job_y_after", 32'(job_y), 2);

      // Line 2: start pulses while busy must be ignored
      for (int i = 0; i < NE; i++) lat[i] = $urandom_range(0, 4);
      d0 = done_cnt;
      run_line(1'b1, 0);
      chk("t3_line_done_once", 32'(done_cnt - d0), 1);
      chk("t3_job_y_wrap", 32'(job_y), 0);

      // Line 3 (job_y 0): engines stalled 10 cycles after start
      for (int i = 0; i < NE; i++) lat[i] = 2;
      run_line(1'b0, 10);
      chk("t4_job_y_after", 32'(job_y), 1);

      // Reset after 4 issues abandons the line
      for (int i = 0; i < NE; i++) lat[i] = 3;
      start = 1'b1;
      step();
      start = 1'b0;
      issue_wait = 0;
      while (issued < 4 && issue_wait < 50) begin step(); issue_wait++; end
      chk("t5_issue_wait", 32'(issued), 4);
      periph_resetn = 1'b0;
      #1;
      chk_reset_outputs("midline");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      periph_resetn = 1'b1;
      drive_engines();
      for (int k = 0; k < 8; k++) step();
      run_line(1'b0, 0);
      chk("t5_job_y_after", 32'(job_y), 1);

      // Simultaneous results on engines 0 and 3 from a fresh collect pointer
      do_reset();
      mask = 4'b1001;
      lat[0] = 4; lat[3] = 3; lat[1] = 1; lat[2] = 1;
      drive_engines();
      run_line(1'b0, 0);
      chk("t6_first_ack", 32'(ack_log[0]), 32'(4'b0001));
      chk("t6_second_ack", 32'(ack_log[1]), 32'(4'b1000));
      chk("t6_ack_consecutive", 32'(ack_cyc[1] - ack_cyc[0]), 1);
      mask = 4'hF;

      // Randomised lines: ready jitter, stray results, random latencies, busy starts
      rand_mode = 1'b1;
      stray_en  = 1'b1;
      for (int ln = 0; ln < 6; ln++) begin
         for (int i = 0; i < NE; i++) lat[i] = $urandom_range(0, 6);
         d0 = done_cnt;
         run_line(1'b1, 0);
         chk("rnd_line_done_once", 32'(done_cnt - d0), 1);
         for (int k = 0; k < 3; k++) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
